capsense_scanner: RTL and testbench

Front-end measurement stage for the capacitive-sense option of the hm2 build (Capsense=1, NumSense=4 on DE0-Nano-SoC Cramps). Scans pads one at a time using RC charge timing:
- actively discharges the pad
- releases it to an external pull-up
- counts clocks until the pad input reads high.
Per-pad counts and hysteresis-filtered touch bits feed the hm2 capsense register/IDROM-visible pins downstream.

---
 rtl/capsense_scanner.sv | 157 +++++++++++++++
 tb/tb_capsense_scanner.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capsense_scanner.sv
// Capacitive-sense pad scanner: discharges each pad, releases it to the external pull-up
// and counts clocks until the synchronized input reads high, then filters touch with hysteresis.
module capsense_scanner #(
  parameter int NumSense        = 4,
  parameter int CountWidth      = 12,
  parameter int DischargeCycles = 256,
  parameter int Hysteresis      = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic [CountWidth-1:0]          threshold,
  input  logic [NumSense-1:0]            sense_in,
  output logic [NumSense-1:0]            sense_oe,
  output logic [NumSense*CountWidth-1:0] count_out,
  output logic [NumSense-1:0]            touch,
  output logic                           scan_done
);

  localparam int IdxWidth   = (NumSense > 1) ? $clog2(NumSense) : 1;
  localparam int TimerWidth = (DischargeCycles > 1) ? $clog2(DischargeCycles) : 1;

  localparam logic [CountWidth-1:0] CountMax  = '1;
  localparam logic [TimerWidth-1:0] TimerLoad = TimerWidth'(DischargeCycles - 1);
  localparam logic [IdxWidth-1:0]   LastIdx   = IdxWidth'(NumSense - 1);
  localparam logic [CountWidth:0]   HystExt   = (CountWidth + 1)'(Hysteresis);

  typedef enum logic [1:0] {
    IDLE,
    DISCHARGE,
    CHARGE,
    STORE
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [IdxWidth-1:0]     idx;
  logic [IdxWidth-1:0]     idx_next;
  logic [TimerWidth-1:0]   timer;
  logic [TimerWidth-1:0]   timer_next;
  logic [CountWidth-1:0]   counter;
  logic [CountWidth-1:0]   counter_next;
  logic [CountWidth-1:0]   counter_inc;
  logic [NumSense-1:0]     sync_meta;
  logic [NumSense-1:0]     sync_in;
  logic [NumSense-1:0]     oe_next;
  logic                    pad_high;
  logic [CountWidth:0]     assert_level;
  logic                    touch_set;
  logic                    touch_clr;

  // Two-flop synchronizer; the charge counter only ever looks at sync_in.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    if (!reset_n) begin
      sync_meta <= '0;
      sync_in   <= '0;
    end else begin
      sync_meta <= sense_in;
      sync_in   <= sync_meta;
    end
  end

  assign pad_high    = sync_in[idx];
  assign counter_inc = (counter == CountMax) ? CountMax : counter + 1'b1;

  // Assert level is one bit wider so threshold+Hysteresis cannot wrap to a small value.
  assign assert_level = {1'b0, threshold} + HystExt;
  assign touch_set    = {1'b0, counter} > assert_level;
  assign touch_clr    = counter < threshold;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      idx     <= '0;
      timer   <= '0;
      counter <= '0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      timer   <= timer_next;
      counter <= counter_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next   = state;
    idx_next     = idx;
    timer_next   = timer;
    counter_next = counter;
    oe_next      = '1;

    unique case (state)
      IDLE: begin
        if (enable) begin
          state_next = DISCHARGE;
          timer_next = TimerLoad;
        end
      end

      DISCHARGE: begin
        if (timer == '0) begin
          state_next   = CHARGE;
          counter_next = '0;
        end else begin
          timer_next = timer - 1'b1;
        end
      end

      // counter holds cycles already spent; counter_inc is this cycle's count (first cycle = 1).
      CHARGE: begin
        counter_next = counter_inc;
        if (pad_high || (counter_inc == CountMax)) begin
          state_next = STORE;
        end
      end

      STORE: begin
        idx_next   = (idx == LastIdx) ? '0 : idx + 1'b1;
        timer_next = TimerLoad;
        state_next = enable ? DISCHARGE : IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Release mask is derived from the next state so sense_oe comes straight off a flop.
    if (state_next == CHARGE) begin
      oe_next[idx_next] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: stored counts and touch bits are real registers that software reads, so reset clears them.
    if (!reset_n) begin
      sense_oe  <= '1;
      count_out <= '0;
      touch     <= '0;
      scan_done <= 1'b0;
    end else begin
      sense_oe  <= oe_next;
      scan_done <= (state == STORE) && (idx == LastIdx);
      if (state == STORE) begin
        count_out[int'(idx)*CountWidth +: CountWidth] <= counter;
        if (touch_set) begin
          touch[idx] <= 1'b1;
        end else if (touch_clr) begin
          touch[idx] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_capsense_scanner.sv
// Bench for capsense_scanner: behavioural pad model drives RC delays, a reference model
// predicts each stored measurement, and a monitor checks every store against the queue.
module tb_capsense_scanner;

  localparam int NS   = 4;
  localparam int CW   = 12;
  localparam int DC   = 4;
  localparam int HY   = 8;
  localparam int MAXC = 4095;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic [CW-1:0]    threshold = '0;
  logic [NS-1:0]    sense_in = '0;
  logic [NS-1:0]    sense_oe;
  logic [NS*CW-1:0] count_out;
  logic [NS-1:0]    touch;
  logic             scan_done;

  capsense_scanner #(
    .NumSense(NS),
    .CountWidth(CW),
    .DischargeCycles(DC),
    .Hysteresis(HY)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .threshold(threshold),
    .sense_in(sense_in),
    .sense_oe(sense_oe),
    .count_out(count_out),
    .touch(touch),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               pad;
    logic [NS*CW-1:0] counts;
    logic [NS-1:0]    touches;
    bit               done;
  } exp_t;

  typedef struct {
    int pad;
    int delay;
  } force_t;

  exp_t   sb[$];
  force_t fq[$];

  int n_checks = 0;
  int n_pass   = 0;

  int m_count[NS];
  bit m_touch[NS];
  int dflt_delay[NS];
  int rel_cnt[NS];
  int cur_delay[NS];

  bit mon_en = 1'b1;
  bit multi_seen = 1'b0;
  int store_count = 0;
  int last_store_pad = -1;
  int last_pad = -1;
  bit pend = 1'b0;
  int pend_pad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Delay D = pad reads high on the D-th released cycle; 0 = never rises.
  function automatic int pick_delay(input int pad);
    for (int k = 0; k < fq.size(); k++) begin
      if (fq[k].pad == pad) begin
        int d;
        d = fq[k].delay;
        fq.delete(k);
        return d;
      end
    end
    if (dflt_delay[pad] < 0) return int'($urandom_range(150, 1));
    return dflt_delay[pad];
  endfunction

  // Reference: count = delay + 2 sync clocks, saturating; touch rule with hysteresis.
  function automatic exp_t model_measure(input int pad, input int delay);
    exp_t e;
    int   c;
    int   thr;
    thr = int'(threshold);
    if (delay == 0 || delay + 2 > MAXC) c = MAXC;
    else c = delay + 2;
    if (c > thr + HY) m_touch[pad] = 1'b1;
    else if (c < thr) m_touch[pad] = 1'b0;
    m_count[pad] = c;
    e.pad  = pad;
    e.done = (pad == NS - 1);
    for (int i = 0; i < NS; i++) begin
      e.counts[i*CW +: CW] = CW'(m_count[i]);
      e.touches[i]         = m_touch[i];
    end
    return e;
  endfunction

  // Pad model: stimulus side; pushes the expected result when a pad is released.
  always @(negedge clk) begin : pad_model
    for (int i = 0; i < NS; i++) begin
      if (sense_oe[i] === 1'b0) begin
        rel_cnt[i]++;
        if (rel_cnt[i] == 1) begin
          cur_delay[i] = pick_delay(i);
          if (mon_en) sb.push_back(model_measure(i, cur_delay[i]));
        end
        if (cur_delay[i] != 0 && rel_cnt[i] >= cur_delay[i]) sense_in[i] = 1'b1;
      end else begin
        rel_cnt[i]  = 0;
        sense_in[i] = 1'b0;
      end
    end
  end

  // Monitor: a release ending marks the STORE cycle; results are visible one cycle later.
  always @(negedge clk) begin : monitor
    int   cur;
    bit   store_now;
    exp_t e;
    if (!mon_en) begin
      last_pad = -1;
      pend     = 1'b0;
    end else begin
      store_now = 1'b0;
      if (pend) begin
        pend      = 1'b0;
        store_now = 1'b1;
        store_count++;
        last_store_pad = pend_pad;
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("store_pad", pend_pad, e.pad);
          check("count_out", count_out, e.counts);
          check("touch", touch, e.touches);
          check("scan_done", scan_done, e.done);
        end
      end
      if (!store_now && scan_done !== 1'b0) check("scan_done_spurious", scan_done, 0);
      if (NS - $countones(sense_oe) > 1) multi_seen = 1'b1;
      cur = -1;
      for (int i = 0; i < NS; i++) if (sense_oe[i] === 1'b0) cur = i;
      if (last_pad >= 0 && cur < 0) begin
        pend     = 1'b1;
        pend_pad = last_pad;
      end
      last_pad = cur;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_stores(input string name, input int n, input int budget);
    int target;
    int c;
    target = store_count + n;
    c = 0;
    while (store_count < target && c < budget) begin
      tick();
      c++;
    end
    check(name, store_count >= target, 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int quiet;
    int c;
    quiet = 0;
    c = 0;
    while (quiet < 12 && c < budget) begin
      tick();
      c++;
      if (sense_oe === '1 && sb.size() == 0 && !pend) quiet++;
      else quiet = 0;
    end
    check(name, quiet >= 12, 1);
  endtask

  task automatic wait_release(input string name, input int pad, input int budget);
    logic [NS-1:0] want;
    int c;
    want = ~(NS'(1) << pad);
    c = 0;
    while (sense_oe !== want && c < budget) begin
      tick();
      c++;
    end
    check(name, sense_oe, want);
  endtask

  task automatic wait_any_release(input int budget);
    int c;
    c = 0;
    while (sense_oe === '1 && c < budget) begin
      tick();
      c++;
    end
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [NS-1:0] oe_and;
    for (int i = 0; i < NS; i++) begin
      m_count[i] = 0;
      m_touch[i] = 1'b0;
      dflt_delay[i] = 20;
      rel_cnt[i] = 0;
      cur_delay[i] = 0;
    end

    // Reset state
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_oe", sense_oe, 4'hF);
    check("rst_count", count_out, 0);
    check("rst_touch", touch, 0);
    check("rst_done", scan_done, 0);
    reset_n = 1'b1;
    threshold = 12'd4000;
    repeat (10) tick();
    check("idle_hold_oe", sense_oe, 4'hF);

    // Fixed 20-clock pads: every stored count is 22
    enable = 1'b1;
    wait_stores("fixed_stores", 8, 400);
    check("fixed_pad0_count", count_out[0 +: CW], 22);
    check("fixed_pad3_count", count_out[3*CW +: CW], 22);

    // Randomized delays and thresholds
    for (int r = 0; r < 2; r++) begin
      enable = 1'b0;
      wait_idle("rand_idle", 400);
      threshold = CW'($urandom_range(120, 20));
      for (int i = 0; i < NS; i++) dflt_delay[i] = -1;
      enable = 1'b1;
      wait_stores("rand_stores", 12, 2500);
    end

    // Hysteresis on pad0: 109 sets, 104 holds, 99 clears
    enable = 1'b0;
    wait_idle("hyst_idle", 400);
    threshold = 12'd100;
    for (int i = 0; i < NS; i++) dflt_delay[i] = 20;
    fq.push_back('{pad: 0, delay: 107});
    fq.push_back('{pad: 0, delay: 102});
    fq.push_back('{pad: 0, delay: 97});
    enable = 1'b1;
    wait_stores("hyst_stores", 12, 600);
    check("hyst_touch0_final", touch[0], 0);

    // Pad2 never rises: saturates at max and scanning moves on
    dflt_delay[2] = 0;
    wait_stores("sat_stores", 4, 4600);
    check("sat_pad2_count", count_out[2*CW +: CW], MAXC);
    check("sat_pad2_touch", touch[2], 1);

    // threshold+Hysteresis beyond max: 4095 never sets, 4000 clears
    enable = 1'b0;
    wait_idle("wide_idle", 4600);
    threshold = 12'd4092;
    dflt_delay[1] = 0;
    dflt_delay[2] = 20;
    fq.push_back('{pad: 2, delay: 3998});
    enable = 1'b1;
    wait_stores("wide_stores", 4, 9000);
    check("wide_pad1_touch", touch[1], 0);
    check("wide_pad2_count", count_out[2*CW +: CW], 4000);
    check("wide_pad2_touch", touch[2], 0);

    // Drop enable during pad1 charge; resume continues at pad2
    enable = 1'b0;
    wait_idle("drop_pre_idle", 4600);
    threshold = 12'd100;
    for (int i = 0; i < NS; i++) dflt_delay[i] = 30;
    enable = 1'b1;
    wait_release("drop_pad1_release", 1, 400);
    enable = 1'b0;
    wait_idle("drop_idle", 400);
    check("drop_stored_pad", last_store_pad, 1);
    oe_and = '1;
    repeat (20) begin
      tick();
      oe_and = oe_and & sense_oe;
    end
    check("drop_idle_oe", oe_and, 4'hF);
    enable = 1'b1;
    wait_any_release(100);
    check("resume_pad2", sense_oe, 4'b1011);

    // Reset in the middle of pad3 charge
    wait_release("rst_pad3_release", 3, 400);
    mon_en = 1'b0;
    reset_n = 1'b0;
    tick();
    check("midrst_oe", sense_oe, 4'hF);
    check("midrst_count", count_out, 0);
    check("midrst_touch", touch, 0);
    check("midrst_done", scan_done, 0);
    sb.delete();
    for (int i = 0; i < NS; i++) begin
      m_count[i] = 0;
      m_touch[i] = 1'b0;
    end
    reset_n = 1'b1;
    mon_en = 1'b1;
    wait_any_release(100);
    check("post_rst_pad0", sense_oe, 4'b1110);
    wait_stores("post_rst_stores", 4, 400);

    enable = 1'b0;
    wait_idle("final_idle", 400);
    check("single_release", multi_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
